ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register sitting directly upstream of the ALU.
- Captures decoded instructions, resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages, and selects immediate vs register B operand.
- Presents registered a, b and alu_op to the ALU, with a valid/ready handshake on both sides.
- Supports flush (branch/exception) and downstream back-pressure.

Parameters:
- width, 32, datapath width of operands and forwarded results.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage can accept this cycle.
- in_alu_op  in  3  ALU op: ADD 010, SUB 011, AND 100, OR 101, NOR 110, XOR 111.
- in_rs_num  in  5  source register number for A.
- in_rs_data  in  width  register-file value for rs.
- in_rt_num  in  5  source register number for B/store.
- in_rt_data  in  width  register-file value for rt.
- in_imm16  in  16  instruction immediate.
- in_use_imm  in  1  B operand = extended immediate.
- in_imm_zext  in  1  1 = zero-extend imm16, 0 = sign-extend.
- in_rd_num  in  5  destination register number.
- fwd_exmem_valid  in  1  EX/MEM result writes a register.
- fwd_exmem_num  in  5  EX/MEM destination register.
- fwd_exmem_data  in  width  EX/MEM result.
- fwd_memwb_valid  in  1  MEM/WB result writes a register.
- fwd_memwb_num  in  5  MEM/WB destination register.
- fwd_memwb_data  in  width  MEM/WB result.
- flush  in  1  discard held and incoming instruction.
- out_valid  out  1  registered instruction valid.
- out_ready  in  1  ALU/EX stage consumes this cycle.
- out_alu_op  out  3  registered op.
- out_a  out  width  ALU operand a.
- out_b  out  width  ALU operand b.
- out_store_data  out  width  forwarded rt, independent of in_use_imm.
- out_rd_num  out  5  registered destination.

Behaviour:
- Clock and reset: one clock (clock); reset_n is asynchronous, active-low.
- Reset: while reset_n = 0, all outputs are zero, including out_valid = 0.
- Single-entry register: in_ready = ~out_valid | out_ready (combinational).
- Load: in_valid & in_ready & ~flush loads on the next edge, so latency is 1 cycle from accept to out_valid.
- Consume without load: out_valid & out_ready with no load clears out_valid.
- Hold: out_valid & ~out_ready holds all outputs stable. Held operands are frozen and are not re-forwarded; the hazard unit is responsible for that case.
- Flush: out_valid goes to 0 next edge. Flush has priority over a simultaneous load, so the incoming instruction is dropped. Data registers may keep stale values; only out_valid matters.
- Forwarding (per operand, rs → A source, rt → rt source), evaluated combinationally at capture:
  - If exmem_valid & exmem_num == num & num != 0, use exmem_data.
  - Else if memwb_valid & memwb_num == num & num != 0, use memwb_data.
  - Else use the register-file data.
  - EX/MEM beats MEM/WB when both match.
  - Register 0 is never forwarded.
- Immediate extension:
  - Zero-extend: {(width-16) zeros, imm16}.
  - Sign-extend: replicate imm16[15].
- Operand selection: out_b = in_use_imm ? extended imm : forwarded rt. out_store_data is always forwarded rt.
- Opcode handling: no checking; in_alu_op passes through unchanged. Codes 000/001 are passed through unchanged.
- Reset mid-operation: asynchronous clear; any held instruction is lost.

Optional Feature:
- Macro: EX_OPERAND_FWD_EN.
- Defined: forwarding as above.
- Undefined: fwd_* inputs are ignored and operands come from in_rs_data/in_rt_data only; the pipeline relies on an external interlock.
- Handshake, flush and immediate logic are identical in both builds.

Decomposition:
- Shared package: ALU op encodings (ALU_ADD..ALU_XOR), register-number width 5, zero-register constant.
- Sub-module fwd_select: one operand's priority forwarding mux; instantiated twice (rs, rt).

Test Plan:
- Reset/ADD path: reset_n low for 2 cycles → out_valid 0 and all outputs 0. Then ADD, rs=1 (data 5), rt=2 (data 7), no forwards, out_ready=1 → next cycle out_valid=1, out_a=5, out_b=7, out_alu_op=010.
- Forward priority: rs=3 with exmem(3, 0xAAAA) and memwb(3, 0xBBBB) both valid → out_a=0xAAAA. Same with only memwb valid → 0xBBBB.
- Zero register: rs=0, rs_data=0, exmem(0, 0x1234) valid → out_a=0. Macro undefined with exmem(3, 0xAAAA) and rs=3, rs_data=9 → out_a=9.
- Immediate: imm16=0x8001, use_imm=1, zext=0 → out_b=0xFFFF8001. zext=1 → out_b=0x00008001. out_store_data = forwarded rt in both cases.
- Back-pressure: out_valid=1, out_ready=0 for 3 cycles, new in_valid → in_ready=0 and outputs unchanged. Then out_ready=1 → new instruction appears next cycle.
- Flush collision: in_valid=1 and flush=1 in the same cycle while holding → next cycle out_valid=0. reset_n pulsed low mid-hold → out_valid=0 immediately (asynchronous).

Source files
------------

// File: rtl/ex_operand_stage_pkg.sv
// ex_operand_stage_pkg
//   Shared definitions for the ID/EX operand stage: ALU opcode encodings,
//   register-number width and the hard-wired zero register.
//   Ports: none (package).
//   Build option: EX_OPERAND_FWD_EN (see ex_operand_stage.sv).
package ex_operand_stage_pkg;

  localparam int REG_NUM_W = 5;
  localparam int ALU_OP_W  = 3;

  // Register 0 always reads as zero, so it is never a forwarding target.
  localparam logic [REG_NUM_W-1:0] ZERO_REG = '0;

  // Codes 000/001 are unassigned and pass through the stage untouched.
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b011,
    ALU_AND = 3'b100,
    ALU_OR  = 3'b101,
    ALU_NOR = 3'b110,
    ALU_XOR = 3'b111
  } alu_op_e;

endpackage

// File: rtl/ex_operand_stage_if.sv
// ex_operand_stage_if
//   Bundles the decode-side input bus, the forwarding buses, flush and the
//   ALU-side output bus of the ID/EX operand stage.
//   Modports:
//     slave  - the operand stage itself (consumes in_*/fwd_*/flush/out_ready,
//              drives in_ready and out_*).
//     master - the surrounding pipeline / driver (the opposite directions).
//   Parameter: DATA_W - operand and forwarded-result width.
interface ex_operand_stage_if
  import ex_operand_stage_pkg::*;
#(
  parameter int DATA_W = 32
) ();

  // Decode side
  logic                 in_valid;
  logic                 in_ready;
  logic [ALU_OP_W-1:0]  in_alu_op;
  logic [REG_NUM_W-1:0] in_rs_num;
  logic [DATA_W-1:0]    in_rs_data;
  logic [REG_NUM_W-1:0] in_rt_num;
  logic [DATA_W-1:0]    in_rt_data;
  logic [15:0]          in_imm16;
  logic                 in_use_imm;
  logic                 in_imm_zext;
  logic [REG_NUM_W-1:0] in_rd_num;

  // Forwarding sources
  logic                 fwd_exmem_valid;
  logic [REG_NUM_W-1:0] fwd_exmem_num;
  logic [DATA_W-1:0]    fwd_exmem_data;
  logic                 fwd_memwb_valid;
  logic [REG_NUM_W-1:0] fwd_memwb_num;
  logic [DATA_W-1:0]    fwd_memwb_data;

  logic                 flush;

  // ALU side
  logic                 out_valid;
  logic                 out_ready;
  logic [ALU_OP_W-1:0]  out_alu_op;
  logic [DATA_W-1:0]    out_a;
  logic [DATA_W-1:0]    out_b;
  logic [DATA_W-1:0]    out_store_data;
  logic [REG_NUM_W-1:0] out_rd_num;

  modport slave (
    input  in_valid, in_alu_op, in_rs_num, in_rs_data, in_rt_num, in_rt_data,
           in_imm16, in_use_imm, in_imm_zext, in_rd_num,
           fwd_exmem_valid, fwd_exmem_num, fwd_exmem_data,
           fwd_memwb_valid, fwd_memwb_num, fwd_memwb_data,
           flush, out_ready,
    output in_ready, out_valid, out_alu_op, out_a, out_b, out_store_data,
           out_rd_num
  );

  modport master (
    output in_valid, in_alu_op, in_rs_num, in_rs_data, in_rt_num, in_rt_data,
           in_imm16, in_use_imm, in_imm_zext, in_rd_num,
           fwd_exmem_valid, fwd_exmem_num, fwd_exmem_data,
           fwd_memwb_valid, fwd_memwb_num, fwd_memwb_data,
           flush, out_ready,
    input  in_ready, out_valid, out_alu_op, out_a, out_b, out_store_data,
           out_rd_num
  );

endinterface

// File: rtl/ex_operand_stage_fwd_select.sv
// ex_operand_stage_fwd_select
//   Priority forwarding mux for one source operand. EX/MEM (the younger
//   result) wins over MEM/WB; register 0 is never forwarded.
//   Ports:
//     num_i          source register number
//     rf_data_i      register-file value for num_i
//     exmem_*_i      EX/MEM forwarding source (valid, dest number, data)
//     memwb_*_i      MEM/WB forwarding source (valid, dest number, data)
//     data_o         resolved operand value (combinational)
module ex_operand_stage_fwd_select
  import ex_operand_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [REG_NUM_W-1:0] num_i,
  input  logic [DATA_W-1:0]    rf_data_i,
  input  logic                 exmem_valid_i,
  input  logic [REG_NUM_W-1:0] exmem_num_i,
  input  logic [DATA_W-1:0]    exmem_data_i,
  input  logic                 memwb_valid_i,
  input  logic [REG_NUM_W-1:0] memwb_num_i,
  input  logic [DATA_W-1:0]    memwb_data_i,
  output logic [DATA_W-1:0]    data_o
);

  logic not_zero;
  logic hit_exmem;
  logic hit_memwb;

  assign not_zero  = (num_i != ZERO_REG);
  assign hit_exmem = exmem_valid_i && (exmem_num_i == num_i) && not_zero;
  assign hit_memwb = memwb_valid_i && (memwb_num_i == num_i) && not_zero;

  always_comb begin
    data_o = rf_data_i;
    if (hit_exmem) begin
      data_o = exmem_data_i;
    end else if (hit_memwb) begin
      data_o = memwb_data_i;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage
//   ID/EX pipeline register feeding the ALU. Captures a decoded instruction,
//   resolves RAW hazards by forwarding from EX/MEM and MEM/WB, extends the
//   immediate and selects the B operand. Single-entry register with
//   valid/ready handshakes on both sides; flush drops held and incoming work.
//   Ports:
//     clock    rising-edge clock
//     reset_n  asynchronous active-low reset (clears all outputs)
//     bus      ex_operand_stage_if.slave: in_* decode bus, fwd_* buses,
//              flush, out_* ALU bus
//   Build option:
//     EX_OPERAND_FWD_EN defined   - operands forwarded from EX/MEM, MEM/WB
//     EX_OPERAND_FWD_EN undefined - fwd_* ignored; operands come straight
//                                   from the register file (external
//                                   interlock assumed)
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  ex_operand_stage_if.slave  bus
);

`ifdef EX_OPERAND_FWD_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] ext_imm(input logic [15:0] imm,
                                                input logic        zext);
    if (zext) begin
      ext_imm = {{(DATA_W-16){1'b0}}, imm};
    end else begin
      ext_imm = {{(DATA_W-16){imm[15]}}, imm};
    end
  endfunction

  logic                 valid_q;
  logic [ALU_OP_W-1:0]  alu_op_q;
  logic [DATA_W-1:0]    a_q, a_d;
  logic [DATA_W-1:0]    b_q, b_d;
  logic [DATA_W-1:0]    store_q;
  logic [REG_NUM_W-1:0] rd_q;

  logic                 load;
  logic                 exmem_valid;
  logic                 memwb_valid;
  logic [DATA_W-1:0]    rt_fwd;

  // With forwarding compiled out the sources can never hit, so the muxes
  // collapse to the register-file values.
  assign exmem_valid = bus.fwd_exmem_valid & FWD_EN;
  assign memwb_valid = bus.fwd_memwb_valid & FWD_EN;

  ex_operand_stage_fwd_select #(.DATA_W(DATA_W)) u_fwd_rs (
    .num_i         (bus.in_rs_num),
    .rf_data_i     (bus.in_rs_data),
    .exmem_valid_i (exmem_valid),
    .exmem_num_i   (bus.fwd_exmem_num),
    .exmem_data_i  (bus.fwd_exmem_data),
    .memwb_valid_i (memwb_valid),
    .memwb_num_i   (bus.fwd_memwb_num),
    .memwb_data_i  (bus.fwd_memwb_data),
    .data_o        (a_d)
  );

  ex_operand_stage_fwd_select #(.DATA_W(DATA_W)) u_fwd_rt (
    .num_i         (bus.in_rt_num),
    .rf_data_i     (bus.in_rt_data),
    .exmem_valid_i (exmem_valid),
    .exmem_num_i   (bus.fwd_exmem_num),
    .exmem_data_i  (bus.fwd_exmem_data),
    .memwb_valid_i (memwb_valid),
    .memwb_num_i   (bus.fwd_memwb_num),
    .memwb_data_i  (bus.fwd_memwb_data),
    .data_o        (rt_fwd)
  );

  assign b_d = bus.in_use_imm ? ext_imm(bus.in_imm16, bus.in_imm_zext) : rt_fwd;

  // Accept when empty or when the held entry leaves this same cycle.
  assign bus.in_ready = ~valid_q | bus.out_ready;
  assign load         = bus.in_valid & bus.in_ready & ~bus.flush;

  // ---- ID/EX register boundary ----
  // Flush beats a simultaneous load. Held operands are frozen, not
  // re-forwarded while stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      alu_op_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      store_q  <= '0;
      rd_q     <= '0;
    end else begin
      if (bus.flush) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
      if (load) begin
        alu_op_q <= bus.in_alu_op;
        a_q      <= a_d;
        b_q      <= b_d;
        store_q  <= rt_fwd;
        rd_q     <= bus.in_rd_num;
      end
    end
  end

  assign bus.out_valid      = valid_q;
  assign bus.out_alu_op     = alu_op_q;
  assign bus.out_a          = a_q;
  assign bus.out_b          = b_q;
  assign bus.out_store_data = store_q;
  assign bus.out_rd_num     = rd_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage
//   Directed bench for ex_operand_stage: a table of single-instruction
//   vectors with hand-computed operands, plus hand-written sequences for
//   reset, back-pressure, flush collision and asynchronous reset mid-hold.
//   Expected forwarding results depend on EX_OPERAND_FWD_EN.
module tb_ex_operand_stage;
  import ex_operand_stage_pkg::*;

`ifdef EX_OPERAND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clock;
  logic reset_n;

  ex_operand_stage_if #(.DATA_W(32)) bus ();

  ex_operand_stage #(.DATA_W(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rs;
    logic [31:0] rsd;
    logic [4:0]  rt;
    logic [31:0] rtd;
    logic [15:0] imm;
    logic        use_imm;
    logic        zext;
    logic [4:0]  rd;
    logic        exv;
    logic [4:0]  exn;
    logic [31:0] exd;
    logic        mwv;
    logic [4:0]  mwn;
    logic [31:0] mwd;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [31:0] exp_st;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.in_alu_op       = v.op;
    bus.in_rs_num       = v.rs;
    bus.in_rs_data      = v.rsd;
    bus.in_rt_num       = v.rt;
    bus.in_rt_data      = v.rtd;
    bus.in_imm16        = v.imm;
    bus.in_use_imm      = v.use_imm;
    bus.in_imm_zext     = v.zext;
    bus.in_rd_num       = v.rd;
    bus.fwd_exmem_valid = v.exv;
    bus.fwd_exmem_num   = v.exn;
    bus.fwd_exmem_data  = v.exd;
    bus.fwd_memwb_valid = v.mwv;
    bus.fwd_memwb_num   = v.mwn;
    bus.fwd_memwb_data  = v.mwd;
  endtask

  // Plain register-register instruction with no forwarding activity.
  function automatic vec_t simple(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] rd);
    vec_t v;
    v = '{op, 5'd1, a, 5'd2, b, 16'h0, 1'b0, 1'b0, rd,
          1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, a, b, b};
    return v;
  endfunction

  initial begin
    // op, rs, rsd, rt, rtd, imm, use_imm, zext, rd,
    // exv, exn, exd, mwv, mwn, mwd, exp_a, exp_b, exp_st
    vecs[0] = '{ALU_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 16'h0, 1'b0, 1'b0, 5'd3,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                32'd5, 32'd7, 32'd7};
    vecs[1] = '{ALU_SUB, 5'd3, 32'd9, 5'd2, 32'd7, 16'h0, 1'b0, 1'b0, 5'd4,
                1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'hBBBB,
                FWD ? 32'hAAAA : 32'd9, 32'd7, 32'd7};
    vecs[2] = '{ALU_AND, 5'd3, 32'd9, 5'd2, 32'd7, 16'h0, 1'b0, 1'b0, 5'd5,
                1'b0, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'hBBBB,
                FWD ? 32'hBBBB : 32'd9, 32'd7, 32'd7};
    vecs[3] = '{ALU_OR, 5'd0, 32'd0, 5'd2, 32'd7, 16'h0, 1'b0, 1'b0, 5'd6,
                1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0,
                32'd0, 32'd7, 32'd7};
    vecs[4] = '{ALU_ADD, 5'd1, 32'd1, 5'd4, 32'h44, 16'h8001, 1'b1, 1'b0,
                5'd7, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h55,
                32'd1, 32'hFFFF8001, FWD ? 32'h55 : 32'h44};
    vecs[5] = '{ALU_OR, 5'd1, 32'd1, 5'd4, 32'h44, 16'h8001, 1'b1, 1'b1,
                5'd8, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h55,
                32'd1, 32'h00008001, FWD ? 32'h55 : 32'h44};
    vecs[6] = '{ALU_XOR, 5'd1, 32'd2, 5'd6, 32'h66, 16'h7FFF, 1'b0, 1'b0,
                5'd9, 1'b1, 5'd6, 32'hE0E0, 1'b1, 5'd6, 32'hF0F0,
                32'd2, FWD ? 32'hE0E0 : 32'h66, FWD ? 32'hE0E0 : 32'h66};
    vecs[7] = '{3'b001, 5'd5, 32'hDEADBEEF, 5'd7, 32'h1, 16'h7FFF, 1'b1,
                1'b0, 5'd31, 1'b1, 5'd7, 32'hCAFE, 1'b0, 5'd0, 32'h0,
                32'hDEADBEEF, 32'h00007FFF, FWD ? 32'hCAFE : 32'h1};
  end

  vec_t v;

  initial begin
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(simple(3'b000, 32'h0, 32'h0, 5'd0));

    // ---- reset ----
    repeat (2) @(negedge clock);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_a", bus.out_a, 32'd0);
    check("rst_b", bus.out_b, 32'd0);
    check("rst_store", bus.out_store_data, 32'd0);
    check("rst_rd_op", {24'h0, bus.out_rd_num, bus.out_alu_op}, 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    reset_n = 1'b1;

    // ---- table vectors, back to back with out_ready held high ----
    for (int i = 0; i < NV; i++) begin
      @(negedge clock);
      drive(vecs[i]);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clock);
      #1;
      check($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("v%0d_op", i), 32'(bus.out_alu_op), 32'(vecs[i].op));
      check($sformatf("v%0d_a", i), bus.out_a, vecs[i].exp_a);
      check($sformatf("v%0d_b", i), bus.out_b, vecs[i].exp_b);
      check($sformatf("v%0d_store", i), bus.out_store_data, vecs[i].exp_st);
      check($sformatf("v%0d_rd", i), 32'(bus.out_rd_num), 32'(vecs[i].rd));
    end

    // Consume without load empties the stage.
    @(negedge clock);
    bus.in_valid = 1'b0;
    @(posedge clock);
    #1;
    check("drain_valid", 32'(bus.out_valid), 32'd0);

    // ---- back-pressure ----
    @(negedge clock);
    drive(simple(ALU_ADD, 32'h11, 32'h22, 5'd10));
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clock);
    #1;
    check("bp_load_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clock);
    drive(simple(ALU_SUB, 32'h33, 32'h44, 5'd11));
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp%0d_in_ready", c), 32'(bus.in_ready), 32'd0);
      @(posedge clock);
      #1;
      check($sformatf("bp%0d_valid", c), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp%0d_a", c), bus.out_a, 32'h11);
      check($sformatf("bp%0d_b", c), bus.out_b, 32'h22);
      check($sformatf("bp%0d_op", c), 32'(bus.out_alu_op), 32'(ALU_ADD));
      check($sformatf("bp%0d_rd", c), 32'(bus.out_rd_num), 32'd10);
      @(negedge clock);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clock);
    #1;
    check("bp_new_valid", 32'(bus.out_valid), 32'd1);
    check("bp_new_a", bus.out_a, 32'h33);
    check("bp_new_b", bus.out_b, 32'h44);
    check("bp_new_op", 32'(bus.out_alu_op), 32'(ALU_SUB));

    // ---- flush collides with a load while holding ----
    @(negedge clock);
    drive(simple(ALU_AND, 32'h55, 32'h66, 5'd12));
    bus.out_ready = 1'b0;
    @(posedge clock);
    #1;
    check("fl_hold_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clock);
    drive(simple(ALU_OR, 32'h77, 32'h88, 5'd13));
    bus.flush = 1'b1;
    @(posedge clock);
    #1;
    check("fl_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clock);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clock);
    #1;
    check("fl_stays_empty", 32'(bus.out_valid), 32'd0);

    // ---- flush with out_ready high and a load pending ----
    @(negedge clock);
    drive(simple(ALU_XOR, 32'h99, 32'hAA, 5'd14));
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    @(posedge clock);
    #1;
    check("fl2_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clock);
    bus.flush = 1'b0;

    // ---- asynchronous reset while holding ----
    drive(simple(ALU_NOR, 32'hBB, 32'hCC, 5'd15));
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clock);
    #1;
    check("ar_hold_valid", 32'(bus.out_valid), 32'd1);
    check("ar_hold_a", bus.out_a, 32'hBB);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_valid", 32'(bus.out_valid), 32'd0);
    check("ar_a", bus.out_a, 32'd0);
    check("ar_b", bus.out_b, 32'd0);
    @(negedge clock);
    reset_n      = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clock);
    #1;
    check("ar_after_valid", 32'(bus.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
